// File: rtl/branch_ctrl_pkg.sv
// Shared types for the branch control unit: FSM state codes, opcodes,
// instruction class latched at decode, and the packed control-strobe vector.
package branch_ctrl_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
   localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
   localparam logic [OP_W-1:0] OP_JAL  = 5'b10100;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   typedef logic [3:0] state_t;

   localparam state_t S_RST  = 4'd0;
   localparam state_t T0     = 4'd1;
   localparam state_t T1     = 4'd2;
   localparam state_t T2     = 4'd3;
   localparam state_t T3     = 4'd4;
   localparam state_t T4     = 4'd5;
   localparam state_t T5     = 4'd6;
   localparam state_t T6     = 4'd7;
   localparam state_t S_HALT = 4'd8;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_BR   = 2'd1,
      CLS_JAL  = 2'd2
   } cls_e;

   typedef struct packed {
      logic pc_out;
      logic pc_in;
      logic inc_pc;
      logic mar_in;
      logic read;
      logic mdr_in;
      logic mdr_out;
      logic ir_in;
      logic gra;
      logic grb;
      logic grc;
      logic r_in;
      logic r_out;
      logic r15_in;
      logic con_in;
      logic y_in;
      logic c_out;
      logic z_in;
      logic zlo_out;
      logic alu_add;
      logic run;
      logic illegal;
   } ctrl_t;

   function automatic logic [OP_W-1:0] op_of(input logic [31:0] ir);
      return ir[31:27];
   endfunction

   // Only multi-step instructions need their class remembered past T3.
   function automatic cls_e cls_of(input logic [OP_W-1:0] op);
      case (op)
         OP_BR:   return CLS_BR;
         OP_JAL:  return CLS_JAL;
         default: return CLS_NONE;
      endcase
   endfunction

endpackage

// File: rtl/branch_control_unit_if.sv
// Datapath-facing bundle of the branch control unit. With BRANCH_COUNT_EN
// defined it also carries the taken/total branch counters.
interface branch_control_unit_if;
   logic [31:0] IR;
   logic        CON;
   logic        Mem_ready;
   logic        Stop;
   logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
   logic        Gra, Grb, Grc, Rin, Rout, R15in, CONin, Yin, Cout, Zin, ZLOout;
   logic        ALU_add;
   logic        Run;
   logic        Illegal;
`ifdef BRANCH_COUNT_EN
   logic [15:0] Br_taken_cnt;
   logic [15:0] Br_total_cnt;

   modport master (
      output IR, CON, Mem_ready, Stop,
      input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
      input  Gra, Grb, Grc, Rin, Rout, R15in, CONin, Yin, Cout, Zin, ZLOout,
      input  ALU_add, Run, Illegal, Br_taken_cnt, Br_total_cnt
   );
   modport slave (
      input  IR, CON, Mem_ready, Stop,
      output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
      output Gra, Grb, Grc, Rin, Rout, R15in, CONin, Yin, Cout, Zin, ZLOout,
      output ALU_add, Run, Illegal, Br_taken_cnt, Br_total_cnt
   );
`else
   modport master (
      output IR, CON, Mem_ready, Stop,
      input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
      input  Gra, Grb, Grc, Rin, Rout, R15in, CONin, Yin, Cout, Zin, ZLOout,
      input  ALU_add, Run, Illegal
   );
   modport slave (
      input  IR, CON, Mem_ready, Stop,
      output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
      output Gra, Grb, Grc, Rin, Rout, R15in, CONin, Yin, Cout, Zin, ZLOout,
      output ALU_add, Run, Illegal
   );
`endif
endinterface

// File: rtl/branch_ctrl_checker.sv
// Safety properties on the strobe vector: PC is never loaded and incremented
// together, and at most one source drives the shared bus.
module branch_ctrl_checker
   import branch_ctrl_pkg::*;
(
   input logic  clk,
   input logic  rst_n,
   input ctrl_t ctrl
);

   a_pcin_incpc: assert property (@(posedge clk) disable iff (!rst_n)
      !(ctrl.pc_in && ctrl.inc_pc));

   a_one_bus_driver: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({ctrl.pc_out, ctrl.r_out, ctrl.mdr_out, ctrl.c_out, ctrl.zlo_out}));

endmodule

// File: rtl/branch_ctrl_decode.sv
// Combinational strobe decode: registered state plus the few live inputs
// (opcode in T3, CON in T6, Stop in T0) mapped onto the control vector.
module branch_ctrl_decode
   import branch_ctrl_pkg::*;
(
   input  state_t          state,
   input  logic [OP_W-1:0] op,
   input  cls_e            cls,
   input  logic            con,
   input  logic            stop,
   input  logic            t1_first,
   output ctrl_t           ctrl
);

   // Strobe vector for the current step.
   always_comb begin
      ctrl = '0;
      case (state)
         T0: begin
            ctrl.run    = 1'b1;
            ctrl.pc_out = ~stop;
            ctrl.mar_in = ~stop;
            ctrl.inc_pc = ~stop;
            ctrl.z_in   = ~stop;
         end
         T1: begin
            ctrl.run    = 1'b1;
            ctrl.read   = 1'b1;
            ctrl.mdr_in = 1'b1;
            ctrl.pc_in  = t1_first;
         end
         T2: begin
            ctrl.run     = 1'b1;
            ctrl.mdr_out = 1'b1;
            ctrl.ir_in   = 1'b1;
         end
         T3: begin
            ctrl.run = 1'b1;
            case (op)
               OP_BR: begin
                  ctrl.gra    = 1'b1;
                  ctrl.r_out  = 1'b1;
                  ctrl.con_in = 1'b1;
               end
               OP_JR: begin
                  ctrl.gra   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.pc_in = 1'b1;
               end
               OP_JAL: begin
                  ctrl.pc_out = 1'b1;
                  ctrl.r15_in = 1'b1;
               end
               OP_NOP:  ctrl.run = 1'b1;
               OP_HALT: ctrl.run = 1'b1;
               default: ctrl.illegal = 1'b1;
            endcase
         end
         T4: begin
            ctrl.run = 1'b1;
            case (cls)
               CLS_BR: begin
                  ctrl.pc_out = 1'b1;
                  ctrl.y_in   = 1'b1;
               end
               CLS_JAL: begin
                  ctrl.gra   = 1'b1;
                  ctrl.r_out = 1'b1;
                  ctrl.pc_in = 1'b1;
               end
               default: ctrl.run = 1'b1;
            endcase
         end
         T5: begin
            ctrl.run     = 1'b1;
            ctrl.c_out   = 1'b1;
            ctrl.alu_add = 1'b1;
            ctrl.z_in    = 1'b1;
         end
         T6: begin
            ctrl.run     = 1'b1;
            ctrl.zlo_out = 1'b1;
            ctrl.pc_in   = con;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/branch_control_unit.sv
// Fetch / control-flow sequencer (BR, JR, JAL, NOP, HALT). Optional branch
// statistics counters are built only when BRANCH_COUNT_EN is defined.
module branch_control_unit
   import branch_ctrl_pkg::*;
#(
   parameter int OPW       = OP_W,
   parameter bit RST_FETCH = 1'b1
) (
   input logic                  Clock,
   input logic                  Reset_n,
   branch_control_unit_if.slave bus
);

   state_t         state_r;
   state_t         state_nx_s;
   cls_e           cls_r;
   logic           t1_seen_r;
   logic [OPW-1:0] op_s;
   ctrl_t          ctrl_s;

   assign op_s = op_of(bus.IR);

   // Next-state sequencing.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_RST: begin
            if (RST_FETCH || !bus.Stop) state_nx_s = T0;
            else                         state_nx_s = S_RST;
         end
         T0: begin
            if (bus.Stop) state_nx_s = T0;
            else          state_nx_s = T1;
         end
         T1: begin
            if (bus.Mem_ready) state_nx_s = T2;
            else               state_nx_s = T1;
         end
         T2: state_nx_s = T3;
         T3: begin
            case (op_s)
               OP_BR, OP_JAL: state_nx_s = T4;
               OP_HALT:       state_nx_s = S_HALT;
               default:       state_nx_s = T0;
            endcase
         end
         T4: begin
            if (cls_r == CLS_BR) state_nx_s = T5;
            else                 state_nx_s = T0;
         end
         T5:      state_nx_s = T6;
         T6:      state_nx_s = T0;
         S_HALT:  state_nx_s = S_HALT;
         default: state_nx_s = S_RST;
      endcase
   end

   // State register; t1_seen_r marks T1 cycles after the first, so PCin pulses once.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r   <= S_RST;
         cls_r     <= CLS_NONE;
         t1_seen_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         t1_seen_r <= (state_r == T1);
         if (state_r == T3) cls_r <= cls_of(op_s);
      end
   end

   branch_ctrl_decode u_decode (
      .state    (state_r),
      .op       (op_s),
      .cls      (cls_r),
      .con      (bus.CON),
      .stop     (bus.Stop),
      .t1_first (~t1_seen_r),
      .ctrl     (ctrl_s)
   );

   branch_ctrl_checker u_checker (
      .clk   (Clock),
      .rst_n (Reset_n),
      .ctrl  (ctrl_s)
   );

   assign bus.PCout   = ctrl_s.pc_out;
   assign bus.PCin    = ctrl_s.pc_in;
   assign bus.IncPC   = ctrl_s.inc_pc;
   assign bus.MARin   = ctrl_s.mar_in;
   assign bus.Read    = ctrl_s.read;
   assign bus.MDRin   = ctrl_s.mdr_in;
   assign bus.MDRout  = ctrl_s.mdr_out;
   assign bus.IRin    = ctrl_s.ir_in;
   assign bus.Gra     = ctrl_s.gra;
   assign bus.Grb     = ctrl_s.grb;
   assign bus.Grc     = ctrl_s.grc;
   assign bus.Rin     = ctrl_s.r_in;
   assign bus.Rout    = ctrl_s.r_out;
   assign bus.R15in   = ctrl_s.r15_in;
   assign bus.CONin   = ctrl_s.con_in;
   assign bus.Yin     = ctrl_s.y_in;
   assign bus.Cout    = ctrl_s.c_out;
   assign bus.Zin     = ctrl_s.z_in;
   assign bus.ZLOout  = ctrl_s.zlo_out;
   assign bus.ALU_add = ctrl_s.alu_add;
   assign bus.Run     = ctrl_s.run;
   assign bus.Illegal = ctrl_s.illegal;

`ifdef BRANCH_COUNT_EN
   logic [15:0] taken_cnt_r;
   logic [15:0] total_cnt_r;

   // Branch statistics, updated once per completed branch in T6; both wrap.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         taken_cnt_r <= 16'd0;
         total_cnt_r <= 16'd0;
      end else if (state_r == T6) begin
         total_cnt_r <= total_cnt_r + 16'd1;
         if (bus.CON) taken_cnt_r <= taken_cnt_r + 16'd1;
      end
   end

   assign bus.Br_taken_cnt = taken_cnt_r;
   assign bus.Br_total_cnt = total_cnt_r;
`endif

endmodule

// File: tb/tb_branch_control_unit.sv
// Bench for branch_control_unit: directed vector table, random instruction
// stream against an instruction-level strobe/PC model, and corner sequences.
module tb_branch_control_unit;

   logic Clock   = 1'b0;
   logic Reset_n = 1'b0;
   always #5 Clock = ~Clock;

   branch_control_unit_if ifc ();

   branch_control_unit #(.OPW(5), .RST_FETCH(1'b1)) dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (ifc.slave)
   );

   localparam logic [21:0] PCOUT  = 22'h200000, PCIN   = 22'h100000, INCPC  = 22'h080000;
   localparam logic [21:0] MARIN  = 22'h040000, READ   = 22'h020000, MDRIN  = 22'h010000;
   localparam logic [21:0] MDROUT = 22'h008000, IRIN   = 22'h004000, GRA    = 22'h002000;
   localparam logic [21:0] ROUT   = 22'h000200, R15IN  = 22'h000100, CONIN  = 22'h000080;
   localparam logic [21:0] YIN    = 22'h000040, COUT   = 22'h000020, ZIN    = 22'h000010;
   localparam logic [21:0] ZLOOUT = 22'h000008, ALUADD = 22'h000004, RUN    = 22'h000002;
   localparam logic [21:0] ILL    = 22'h000001;
   localparam logic [21:0] T0V    = PCOUT | MARIN | INCPC | ZIN | RUN;

   logic [21:0] obs;
   assign obs = {ifc.PCout, ifc.PCin, ifc.IncPC, ifc.MARin, ifc.Read, ifc.MDRin, ifc.MDRout,
                 ifc.IRin, ifc.Gra, ifc.Grb, ifc.Grc, ifc.Rin, ifc.Rout, ifc.R15in, ifc.CONin,
                 ifc.Yin, ifc.Cout, ifc.Zin, ifc.ZLOout, ifc.ALU_add, ifc.Run, ifc.Illegal};

   int errors = 0;
   int checks = 0;
   logic [21:0] exp_q[$];
   logic [31:0] pc_m, z_m, y_m;
   logic [31:0] rf [16];
   int exp_taken = 0;
   int exp_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Expected per-cycle strobe sequence of one instruction, built from the step table.
   task automatic build_seq(input logic [31:0] ir, input bit con, input int w);
      logic [4:0] op;
      op = ir[31:27];
      exp_q.delete();
      exp_q.push_back(T0V);
      exp_q.push_back(READ | MDRIN | PCIN | RUN);
      for (int i = 0; i < w; i++) exp_q.push_back(READ | MDRIN | RUN);
      exp_q.push_back(MDROUT | IRIN | RUN);
      case (op)
         5'b10010: begin
            exp_q.push_back(GRA | ROUT | CONIN | RUN);
            exp_q.push_back(PCOUT | YIN | RUN);
            exp_q.push_back(COUT | ALUADD | ZIN | RUN);
            exp_q.push_back(ZLOOUT | RUN | (con ? PCIN : 22'h0));
         end
         5'b10011: exp_q.push_back(GRA | ROUT | PCIN | RUN);
         5'b10100: begin
            exp_q.push_back(PCOUT | R15IN | RUN);
            exp_q.push_back(GRA | ROUT | PCIN | RUN);
         end
         5'b11010, 5'b11011: exp_q.push_back(RUN);
         default: exp_q.push_back(ILL | RUN);
      endcase
   endtask

   // Toy datapath reacting to the DUT's strobes for one clock edge.
   task automatic dp_step();
      logic [31:0] bus_v, sext_v, rv;
      logic [3:0]  ra;
      ra     = ifc.IR[26:23];
      sext_v = {{13{ifc.IR[18]}}, ifc.IR[18:0]};
      rv     = rf[ra];
      bus_v  = ifc.PCout ? pc_m : ifc.Rout ? rv : ifc.Cout ? sext_v : ifc.ZLOout ? z_m : 32'h0;
      if (ifc.Yin)   y_m = bus_v;
      if (ifc.PCin)  pc_m = ifc.Rout ? rv : z_m;
      if (ifc.R15in) rf[15] = bus_v;
      if (ifc.Zin)   z_m = ifc.IncPC ? pc_m + 32'd1 : (ifc.ALU_add ? y_m + bus_v : z_m);
   endtask

   task automatic tick();
      dp_step();
      @(posedge Clock);
      @(negedge Clock);
   endtask

   // Runs one instruction from T0 until the DUT is back in T0; returns cycles taken.
   task automatic run_instr(input string name, input logic [31:0] ir, input bit con,
                            input int w, output int lat);
      int k;
      bit done;
      build_seq(ir, con, w);
      ifc.IR  = ir;
      ifc.CON = con;
      #1;
      k    = 0;
      done = 1'b0;
      while (!done) begin
         if (k < exp_q.size()) check($sformatf("%s cyc%0d", name, k), 32'(obs), 32'(exp_q[k]));
         else                  check($sformatf("%s overrun%0d", name, k), 32'(obs), 32'(T0V));
         ifc.Mem_ready = !(k >= 1 && k <= w);
         tick();
         k++;
         if (obs == T0V) begin
            done = 1'b1;
         end else if (k > 40) begin
            check({name, " timeout"}, 32'(obs), 32'(T0V));
            done = 1'b1;
         end
      end
      if (ir[31:27] == 5'b10010) begin
         exp_total++;
         if (con) exp_taken++;
      end
      lat = k;
   endtask

   typedef struct {
      logic [31:0] ir;
      bit          con;
      int          w;
      logic [31:0] pc0;
      int          lat;
      logic [31:0] pc1;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, w, sel;
      bit con;
      logic [4:0]  op;
      logic [3:0]  ra;
      logic [31:0] ir, pc0, exp_pc, link;

      ifc.IR = 32'h0; ifc.CON = 1'b0; ifc.Mem_ready = 1'b1; ifc.Stop = 1'b0;
      for (int i = 0; i < 16; i++) rf[i] = 32'h100 + 32'(i);
      pc_m = 32'h0B; z_m = 32'h0; y_m = 32'h0;

      tbl[0] = '{32'h9318_0019, 1'b1, 0, 32'h0B, 7,  32'h25};
      tbl[1] = '{32'h9318_0019, 1'b0, 0, 32'h0B, 7,  32'h0C};
      tbl[2] = '{32'h9318_0019, 1'b1, 3, 32'h0B, 10, 32'h25};
      tbl[3] = '{32'hA200_0000, 1'b0, 0, 32'h40, 5,  32'h104};
      tbl[4] = '{32'h9980_0000, 1'b0, 0, 32'h50, 4,  32'h103};
      tbl[5] = '{32'hD000_0000, 1'b0, 0, 32'h60, 4,  32'h61};
      tbl[6] = '{32'hF800_0000, 1'b0, 2, 32'h70, 6,  32'h71};
      tbl[7] = '{32'h9307_FFFE, 1'b1, 1, 32'h20, 8,  32'h1F};

      #12;
      check("reset_outputs", 32'(obs), 32'h0);
`ifdef BRANCH_COUNT_EN
      check("reset_taken_cnt", 32'(ifc.Br_taken_cnt), 32'h0);
      check("reset_total_cnt", 32'(ifc.Br_total_cnt), 32'h0);
`endif
      @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
      check("first_t0", 32'(obs), 32'(T0V));

      ifc.Stop = 1'b1; #1;
      check("stop_idle", 32'(obs), 32'(RUN));
      tick();
      check("stop_hold", 32'(obs), 32'(RUN));
      check("stop_pc_kept", pc_m, 32'h0B);
      ifc.Stop = 1'b0; #1;
      check("stop_release", 32'(obs), 32'(T0V));

      for (int i = 0; i < 8; i++) begin
         pc_m = tbl[i].pc0;
         run_instr($sformatf("vec%0d", i), tbl[i].ir, tbl[i].con, tbl[i].w, lat);
         check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("vec%0d pc", i), pc_m, tbl[i].pc1);
      end
      check("jal_link_r15", rf[15], 32'h41);

      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0: op = 5'b10010;
            1: op = 5'b10011;
            2: op = 5'b10100;
            3: op = 5'b11010;
            default: begin
               op = 5'(($urandom_range(0, 31)));
               while (op == 5'b10010 || op == 5'b10011 || op == 5'b10100 ||
                      op == 5'b11010 || op == 5'b11011) op = op + 5'd1;
            end
         endcase
         ra  = 4'($urandom_range(0, 15));
         ir  = {op, ra, 4'($urandom_range(0, 15)), 19'($urandom_range(0, 32'h7FFFF))};
         con = 1'($urandom_range(0, 1));
         w   = int'($urandom_range(0, 3));
         pc0  = pc_m;
         link = pc0 + 32'd1;
         case (op)
            5'b10010: exp_pc = con ? link + {{13{ir[18]}}, ir[18:0]} : link;
            5'b10011: exp_pc = rf[ra];
            5'b10100: exp_pc = (ra == 4'd15) ? link : rf[ra];
            default:  exp_pc = link;
         endcase
         run_instr($sformatf("rnd%0d", n), ir, con, w, lat);
         check($sformatf("rnd%0d pc", n), pc_m, exp_pc);
      end

`ifdef BRANCH_COUNT_EN
      check("taken_cnt", 32'(ifc.Br_taken_cnt), 32'(exp_taken));
      check("total_cnt", 32'(ifc.Br_total_cnt), 32'(exp_total));
`endif

      // Branch interrupted by reset between clock edges in T5.
      ifc.IR = 32'h9318_0019; ifc.CON = 1'b1; ifc.Mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) tick();
      check("t5_before_reset", 32'(obs), 32'(COUT | ALUADD | ZIN | RUN));
      #2;
      Reset_n = 1'b0;
      #1;
      check("reset_mid_t5", 32'(obs), 32'h0);
`ifdef BRANCH_COUNT_EN
      check("reset_mid_taken_cnt", 32'(ifc.Br_taken_cnt), 32'h0);
      check("reset_mid_total_cnt", 32'(ifc.Br_total_cnt), 32'h0);
`endif
      @(negedge Clock);
      Reset_n = 1'b1;
      pc_m = 32'h0B;
      @(negedge Clock);
      check("t0_after_reset", 32'(obs), 32'(T0V));

      // Halt: fetch and decode, then frozen with everything low until reset.
      build_seq(32'hD800_0000, 1'b0, 0);
      ifc.IR = 32'hD800_0000; ifc.CON = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("halt cyc%0d", k), 32'(obs), 32'(exp_q[k]));
         tick();
      end
      for (int k = 0; k < 100; k++) begin
         check($sformatf("halted%0d", k), 32'(obs), 32'h0);
         tick();
      end
      Reset_n = 1'b0; #1;
      check("halt_reset", 32'(obs), 32'h0);
      @(negedge Clock);
      Reset_n = 1'b1;
      @(negedge Clock);
      check("halt_exit_t0", 32'(obs), 32'(T0V));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
